cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_rsp_fifo.sv | 53 +++++
 rtl/cordic_sched.sv | 116 +++++++++++
 tb/tb_cordic_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared defaults and response entry type for the CORDIC scheduler
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;
  localparam int CORDIC_LAT   = 15;
  localparam int CORDIC_DEPTH = 4;

  // 1/K_hyp prescale so the hyperbolic iterations land on unit-gain cosh/sinh
  localparam logic [15:0] CORDIC_X_INIT = 16'sd19784;

  typedef struct packed {
    logic                    id;
    logic [CORDIC_WIDTH-1:0] cosh;
    logic [CORDIC_WIDTH-1:0] sinh;
  } rsp_entry_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// rtl/cordic_rsp_fifo.sv - non-fall-through response FIFO with occupancy count
module cordic_rsp_fifo
  import cordic_pkg::*;
#(
  parameter int  DEPTH   = CORDIC_DEPTH,
  parameter type entry_t = rsp_entry_t
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is read from storage only, so a push becomes visible the cycle after.
  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - two-requester credit-gated scheduler for a fixed-latency CORDIC datapath
// CORDIC_SCHED_FIXED_PRIO_EN: requester 0 always wins contention (default build is round-robin)
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int               WIDTH  = CORDIC_WIDTH,
  parameter int               LAT    = CORDIC_LAT,
  parameter int               DEPTH  = CORDIC_DEPTH,
  parameter logic [WIDTH-1:0] X_INIT = CORDIC_X_INIT
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [31:0]      req0_theta,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_theta,
  output logic             req1_ready,
  output logic [31:0]      dp_theta,
  output logic [WIDTH-1:0] dp_x,
  output logic [WIDTH-1:0] dp_y,
  input  logic [WIDTH-1:0] dp_cosh,
  input  logic [WIDTH-1:0] dp_sinh,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_cosh,
  output logic [WIDTH-1:0] rsp_sinh,
  input  logic             rsp_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] cosh;
    logic [WIDTH-1:0] sinh;
  } entry_t;

  logic [LAT:0]  tag_valid;
  logic [LAT:0]  tag_id;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          has_credit;
  logic          pref;
  logic          win_id;
  logic          accept;
  logic          tail;
  entry_t        push_data;
  entry_t        head;

`ifdef CORDIC_SCHED_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic ptr;

  always_ff @(posedge clock) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~win_id;
  end

  assign pref = ptr;
`endif

  // Credits come only from registered counts; rst_n gating keeps ready low through reset.
  assign has_credit = rst_n && ((inflight + fifo_count) < CW'(DEPTH));
  assign win_id     = req1_valid && (!req0_valid || pref);
  assign req0_ready = has_credit && !win_id;
  assign req1_ready = has_credit && win_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign tail       = tag_valid[LAT];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      dp_theta  <= '0;
      dp_x      <= '0;
      dp_y      <= '0;
      tag_valid <= '0;
      tag_id    <= '0;
      inflight  <= '0;
    end else begin
      tag_valid <= {tag_valid[LAT-1:0], accept};
      tag_id    <= {tag_id[LAT-1:0], win_id};
      if (accept) begin
        dp_theta <= win_id ? req1_theta : req0_theta;
        dp_x     <= X_INIT;
        dp_y     <= '0;
      end
      case ({accept, tail})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push_data = '{id: tag_id[LAT], cosh: dp_cosh, sinh: dp_sinh};

  cordic_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (tail),
    .push_data (push_data),
    .pop       (rsp_valid && rsp_ready),
    .head      (head),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign rsp_id   = head.id;
  assign rsp_cosh = head.cosh;
  assign rsp_sinh = head.sinh;

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - directed self-checking bench for cordic_sched with a fixed-latency datapath model
module tb_cordic_sched;

  localparam int          LAT  = 15;
  localparam logic [15:0] XI   = 16'd19784;
  localparam logic [15:0] SMSK = 16'hA5A5;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_theta = '0, req1_theta = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] dp_theta;
  logic [15:0] dp_x, dp_y, dp_cosh, dp_sinh;
  logic        rsp_valid, rsp_id, rsp_ready = 1'b0;
  logic [15:0] rsp_cosh, rsp_sinh;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  cordic_sched dut (
    .clock(clock), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_theta(req0_theta), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_theta(req1_theta), .req1_ready(req1_ready),
    .dp_theta(dp_theta), .dp_x(dp_x), .dp_y(dp_y),
    .dp_cosh(dp_cosh), .dp_sinh(dp_sinh),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cosh(rsp_cosh), .rsp_sinh(rsp_sinh),
    .rsp_ready(rsp_ready)
  );

  always #5 clock = ~clock;

  // Datapath model: samples dp_* one edge after they load, result visible LAT edges later.
  logic [15:0] pc [LAT];
  logic [15:0] ps [LAT];
  always @(posedge clock) begin
    pc[0] <= dp_theta[15:0] + dp_x;
    ps[0] <= dp_theta[15:0] ^ dp_y ^ SMSK;
    for (int k = 1; k < LAT; k++) begin
      pc[k] <= pc[k-1];
      ps[k] <= ps[k-1];
    end
  end
  assign dp_cosh = pc[LAT-1];
  assign dp_sinh = ps[LAT-1];

  typedef struct { logic id; logic [31:0] theta; int cyc; } acc_t;
  typedef struct { logic id; logic [15:0] cosh; logic [15:0] sinh; int cyc; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  always @(posedge clock) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) acc_q.push_back('{1'b0, req0_theta, cyc});
      if (req1_valid && req1_ready) acc_q.push_back('{1'b1, req1_theta, cyc});
      if (rsp_valid && rsp_ready)   rsp_q.push_back('{rsp_id, rsp_cosh, rsp_sinh, cyc});
    end
    cyc <= cyc + 1;
  end

  task automatic apply_reset();
    @(negedge clock);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    acc_q.delete();
    rsp_q.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int g = 0;
    while (rsp_q.size() < n && g < budget) begin
      @(negedge clock);
      g++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (dp_theta !== 32'd0) begin errors++; $display("FAIL reset_dp_theta got=%0h exp=0", dp_theta); end
    checks++; if (dp_x !== 16'd0) begin errors++; $display("FAIL reset_dp_x got=%0h exp=0", dp_x); end
    checks++; if (dp_y !== 16'd0) begin errors++; $display("FAIL reset_dp_y got=%0h exp=0", dp_y); end
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req0_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_theta = 32'd0;
    @(negedge clock);
    req0_valid = 1'b0;
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL single_accepts got=%0d exp=1", acc_q.size()); end
    checks++; if (dp_x !== XI) begin errors++; $display("FAIL single_dp_x got=%0d exp=%0d", dp_x, XI); end
    wait_rsp(1, 40);
    checks++; if (rsp_q.size() !== 1) begin errors++; $display("FAIL single_rsp_count got=%0d exp=1", rsp_q.size()); end
    if (rsp_q.size() == 1 && acc_q.size() == 1) begin
      checks++; if (rsp_q[0].id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", rsp_q[0].id); end
      checks++; if (rsp_q[0].cosh !== XI) begin errors++; $display("FAIL single_cosh got=%0d exp=%0d", rsp_q[0].cosh, XI); end
      checks++; if (rsp_q[0].sinh !== SMSK) begin errors++; $display("FAIL single_sinh got=%0h exp=%0h", rsp_q[0].sinh, SMSK); end
      // rsp_valid rises after edge accept+LAT+1, so with rsp_ready held the pop is one edge later
      checks++;
      if (rsp_q[0].cyc - acc_q[0].cyc !== LAT + 2) begin
        errors++; $display("FAIL single_latency got=%0d exp=%0d", rsp_q[0].cyc - acc_q[0].cyc, LAT + 2);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ids;
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
    exp_ids = 4'b0000;
`else
    exp_ids = 4'b1010;
`endif
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_theta = 32'(100 + i); req1_theta = 32'(200 + i);
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL contention_accepts got=%0d exp=4", acc_q.size()); end
    wait_rsp(4, 60);
    checks++; if (rsp_q.size() !== 4) begin errors++; $display("FAIL contention_rsp_count got=%0d exp=4", rsp_q.size()); end
    if (acc_q.size() == 4 && rsp_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        logic [15:0] ec;
        ec = 16'(exp_ids[k] ? 200 + k : 100 + k) + XI;
        checks++; if (acc_q[k].id !== exp_ids[k]) begin errors++; $display("FAIL contention_grant%0d got=%b exp=%b", k, acc_q[k].id, exp_ids[k]); end
        checks++; if (rsp_q[k].id !== exp_ids[k]) begin errors++; $display("FAIL contention_rsp_id%0d got=%b exp=%b", k, rsp_q[k].id, exp_ids[k]); end
        checks++; if (rsp_q[k].cosh !== ec) begin errors++; $display("FAIL contention_cosh%0d got=%0d exp=%0d", k, rsp_q[k].cosh, ec); end
      end
    end
  endtask

  task automatic test_backpressure();
    int target;
    int g;
    apply_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req0_theta = 32'(300 + i);
      @(negedge clock);
    end
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", acc_q.size()); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", req0_ready); end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    checks++; if (rsp_q.size() !== 1) begin errors++; $display("FAIL bp_one_pop got=%0d exp=1", rsp_q.size()); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", req0_ready); end
    @(negedge clock);
    req0_valid = 1'b0;
    checks++; if (acc_q.size() !== 5) begin errors++; $display("FAIL bp_new_accept got=%0d exp=5", acc_q.size()); end
    if (acc_q.size() == 5 && rsp_q.size() == 1) begin
      checks++;
      if (acc_q[4].cyc !== rsp_q[0].cyc + 1) begin
        errors++; $display("FAIL bp_accept_timing got=%0d exp=%0d", acc_q[4].cyc, rsp_q[0].cyc + 1);
      end
      // Pop on the very edge the fifth result is pushed: all credits in use.
      target = acc_q[4].cyc + LAT + 1;
      g = 0;
      while (cyc != target && g < 60) begin
        @(negedge clock);
        g++;
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      checks++; if (rsp_q.size() !== 2) begin errors++; $display("FAIL bp_pushpop_count got=%0d exp=2", rsp_q.size()); end
      if (rsp_q.size() == 2) begin
        checks++; if (rsp_q[1].cyc !== target) begin errors++; $display("FAIL bp_pushpop_edge got=%0d exp=%0d", rsp_q[1].cyc, target); end
      end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_pushpop_valid got=%b exp=1", rsp_valid); end
      rsp_ready = 1'b1;
      wait_rsp(5, 20);
      checks++; if (rsp_q.size() !== 5) begin errors++; $display("FAIL bp_drain got=%0d exp=5", rsp_q.size()); end
      if (rsp_q.size() == 5) begin
        for (int k = 0; k < 5; k++) begin
          logic [15:0] ec;
          ec = acc_q[k].theta[15:0] + XI;
          checks++; if (rsp_q[k].cosh !== ec) begin errors++; $display("FAIL bp_order%0d got=%0d exp=%0d", k, rsp_q[k].cosh, ec); end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_theta = 32'(500 + i);
      @(negedge clock);
    end
    req0_valid = 1'b0;
    checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL midreset_accepts got=%0d exp=3", acc_q.size()); end
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", req0_ready); end
    repeat (40) @(negedge clock);
    checks++; if (rsp_q.size() !== 0) begin errors++; $display("FAIL midreset_no_rsp got=%0d exp=0", rsp_q.size()); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] th [10];
    int i = 0;
    int g = 0;
    for (int k = 0; k < 10; k++) th[k] = 32'(k * 4099 + 11);
    apply_reset();
    rsp_ready = 1'b1;
    while (i < 10 && g < 400) begin
      req0_valid = (i % 2 == 0); req1_valid = (i % 2 == 1);
      req0_theta = th[i]; req1_theta = th[i];
      @(negedge clock);
      g++;
      if (acc_q.size() > i) i++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (i !== 10) begin errors++; $display("FAIL wrap_accepts got=%0d exp=10", i); end
    wait_rsp(10, 60);
    checks++; if (rsp_q.size() !== 10) begin errors++; $display("FAIL wrap_rsp_count got=%0d exp=10", rsp_q.size()); end
    if (rsp_q.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        logic [15:0] ec, es;
        logic        eid;
        ec = th[k][15:0] + XI;
        es = th[k][15:0] ^ SMSK;
        eid = (k % 2 == 1);
        checks++; if (rsp_q[k].id !== eid) begin errors++; $display("FAIL wrap_id%0d got=%b exp=%b", k, rsp_q[k].id, eid); end
        checks++; if (rsp_q[k].cosh !== ec || rsp_q[k].sinh !== es) begin
          errors++; $display("FAIL wrap_data%0d got=%0h/%0h exp=%0h/%0h", k, rsp_q[k].cosh, rsp_q[k].sinh, ec, es);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
